// File: rtl/dec_stage_pkg.sv
// Shared constants and types for the decode stage: field widths, supported
// opcodes and the instruction class decoder.
package dec_stage_pkg;

    localparam int unsigned OpcodeSize  = 7;
    localparam int unsigned Func3Size   = 3;
    localparam int unsigned Func7Size   = 7;
    localparam int unsigned DataSize    = 32;
    localparam int unsigned RegAddrSize = 5;

    localparam logic [OpcodeSize-1:0] Opcode_Type_I = 7'b0010011;
    localparam logic [OpcodeSize-1:0] Opcode_Type_R = 7'b0110011;

    localparam logic [DataSize-1:0] DataBusReset = '0;

    typedef enum logic [1:0] {
        InstTypeI,
        InstTypeR,
        InstIllegal
    } inst_type_e;

    function automatic inst_type_e decode_type(input logic [OpcodeSize-1:0] op);
        case (op)
            Opcode_Type_I: return InstTypeI;
            Opcode_Type_R: return InstTypeR;
            default:       return InstIllegal;
        endcase
    endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two asynchronous read ports with write-through
// bypass, one synchronous write port, x0 hardwired to zero.
module reg_file
    import dec_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = DataSize,
    parameter int unsigned REG_NUM = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [RegAddrSize-1:0] raddr1_i,
    output logic [DATA_W-1:0]      rdata1_o,
    input  logic [RegAddrSize-1:0] raddr2_i,
    output logic [DATA_W-1:0]      rdata2_o,
    input  logic                   we_i,
    input  logic [RegAddrSize-1:0] waddr_i,
    input  logic [DATA_W-1:0]      wdata_i
);

    logic [DATA_W-1:0] regs_q [REG_NUM];
    logic [DATA_W-1:0] regs_d [REG_NUM];
    logic              wr_en;

    assign wr_en = we_i && (waddr_i != '0) && (32'(waddr_i) < REG_NUM);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= DATA_W'(DataBusReset);
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Same-cycle write is forwarded so the reader never sees the stale value.
    assign rdata1_o = (raddr1_i == '0)                     ? '0      :
                      (wr_en && (waddr_i == raddr1_i))     ? wdata_i : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == '0)                     ? '0      :
                      (wr_en && (waddr_i == raddr2_i))     ? wdata_i : regs_q[raddr2_i];

endmodule

// File: rtl/dec_stage.sv
// Decode stage: splits RV32 I/R-type instructions into ALU fields, reads
// operands and holds the decoded bundle in a ready/valid output register.
module dec_stage
    import dec_stage_pkg::*;
#(
    parameter int unsigned DATA_W  = DataSize,
    parameter int unsigned REG_NUM = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   instValid,
    input  logic [31:0]            instIn,
    input  logic [DATA_W-1:0]      instPc,
    output logic                   instReady,
    input  logic                   flush,
    input  logic                   wbEn,
    input  logic [RegAddrSize-1:0] wbAddr,
    input  logic [DATA_W-1:0]      wbData,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [OpcodeSize-1:0]  opcode,
    output logic [Func3Size-1:0]   opFunc3,
    output logic [Func7Size-1:0]   opFunc7,
    output logic [DATA_W-1:0]      dataSource1,
    output logic [DATA_W-1:0]      dataSource2,
    output logic [DATA_W-1:0]      immValue,
    output logic [RegAddrSize-1:0] rdAddr,
    output logic [DATA_W-1:0]      pcOut,
    output logic                   illegal
);

    logic [RegAddrSize-1:0] rs1, rs2;
    logic [DATA_W-1:0]      rdata1, rdata2, imm_i;
    inst_type_e             inst_type;
    logic                   accept, held;

    logic                   out_valid_q, out_valid_d;
    logic [OpcodeSize-1:0]  opcode_q, opcode_d;
    logic [Func3Size-1:0]   func3_q, func3_d;
    logic [Func7Size-1:0]   func7_q, func7_d;
    logic [DATA_W-1:0]      src1_q, src1_d, src2_q, src2_d, imm_q, imm_d, pc_q, pc_d;
    logic [RegAddrSize-1:0] rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic                   illegal_q, illegal_d;

    assign rs1       = instIn[19:15];
    assign rs2       = instIn[24:20];
    assign inst_type = decode_type(instIn[6:0]);
    assign imm_i     = {{(DATA_W-12){instIn[31]}}, instIn[31:20]};
    assign instReady = (!out_valid_q || outReady) && !flush;
    assign accept    = instValid && instReady;
    assign held      = out_valid_q && !outReady;

    reg_file #(
        .DATA_W  (DATA_W),
        .REG_NUM (REG_NUM)
    ) u_reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .raddr1_i (rs1),
        .rdata1_o (rdata1),
        .raddr2_i (rs2),
        .rdata2_o (rdata2),
        .we_i     (wbEn),
        .waddr_i  (wbAddr),
        .wdata_i  (wbData)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        opcode_d    = opcode_q;
        func3_d     = func3_q;
        func7_d     = func7_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        rd_d        = rd_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        illegal_d   = illegal_q;

        if (accept) begin
            out_valid_d = 1'b1;
            opcode_d    = instIn[6:0];
            func3_d     = instIn[14:12];
            func7_d     = instIn[31:25];
            pc_d        = instPc;
            rs1_d       = rs1;
            rs2_d       = rs2;
            case (inst_type)
                InstTypeI: begin
                    src1_d    = rdata1;
                    src2_d    = '0;
                    imm_d     = imm_i;
                    rd_d      = instIn[11:7];
                    illegal_d = 1'b0;
                end
                InstTypeR: begin
                    src1_d    = rdata1;
                    src2_d    = rdata2;
                    imm_d     = '0;
                    rd_d      = instIn[11:7];
                    illegal_d = 1'b0;
                end
                default: begin
                    src1_d    = '0;
                    src2_d    = '0;
                    imm_d     = '0;
                    rd_d      = '0;
                    illegal_d = 1'b1;
                end
            endcase
        end else if (flush || (out_valid_q && outReady)) begin
            out_valid_d = 1'b0;
        end else if (held && !illegal_q && wbEn && (wbAddr != '0)) begin
            // A stalled bundle keeps tracking writebacks to its source registers.
            if (wbAddr == rs1_q) begin
                src1_d = wbData;
            end
            if ((wbAddr == rs2_q) && (opcode_q == Opcode_Type_R)) begin
                src2_d = wbData;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            opcode_q    <= '0;
            func3_q     <= '0;
            func7_q     <= '0;
            src1_q      <= DATA_W'(DataBusReset);
            src2_q      <= DATA_W'(DataBusReset);
            imm_q       <= DATA_W'(DataBusReset);
            pc_q        <= DATA_W'(DataBusReset);
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            opcode_q    <= opcode_d;
            func3_q     <= func3_d;
            func7_q     <= func7_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            illegal_q   <= illegal_d;
        end
    end

    assign outValid    = out_valid_q;
    assign opcode      = opcode_q;
    assign opFunc3     = func3_q;
    assign opFunc7     = func7_q;
    assign dataSource1 = src1_q;
    assign dataSource2 = src2_q;
    assign immValue    = imm_q;
    assign rdAddr      = rd_q;
    assign pcOut       = pc_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_dec_stage.sv
// Bench for dec_stage: constant vector table, directed stall/flush/reset
// sequences and random traffic checked against a register-array model.
module tb_dec_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instValid = 1'b0;
    logic [31:0] instIn = '0;
    logic [31:0] instPc = '0;
    logic        instReady;
    logic        flush = 1'b0;
    logic        wbEn = 1'b0;
    logic [4:0]  wbAddr = '0;
    logic [31:0] wbData = '0;
    logic        outValid;
    logic        outReady = 1'b0;
    logic [6:0]  opcode;
    logic [2:0]  opFunc3;
    logic [6:0]  opFunc7;
    logic [31:0] dataSource1, dataSource2, immValue, pcOut;
    logic [4:0]  rdAddr;
    logic        illegal;

    dec_stage #(
        .DATA_W  (32),
        .REG_NUM (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instValid   (instValid),
        .instIn      (instIn),
        .instPc      (instPc),
        .instReady   (instReady),
        .flush       (flush),
        .wbEn        (wbEn),
        .wbAddr      (wbAddr),
        .wbData      (wbData),
        .outValid    (outValid),
        .outReady    (outReady),
        .opcode      (opcode),
        .opFunc3     (opFunc3),
        .opFunc7     (opFunc7),
        .dataSource1 (dataSource1),
        .dataSource2 (dataSource2),
        .immValue    (immValue),
        .rdAddr      (rdAddr),
        .pcOut       (pcOut),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] ds1;
        logic [31:0] ds2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        ill;
    } bundle_t;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] pc;
        bundle_t     exp;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;

    // Reference state: architectural registers plus the bundle currently shown.
    logic [31:0] mregs [32];
    logic        m_valid = 1'b0;
    logic [31:0] m_inst  = '0;
    logic [31:0] m_pc    = '0;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_bundle(input string tag, input bundle_t e);
        chk({tag, "_opcode"},  opcode,      e.op);
        chk({tag, "_func3"},   opFunc3,     e.f3);
        chk({tag, "_func7"},   opFunc7,     e.f7);
        chk({tag, "_ds1"},     dataSource1, e.ds1);
        chk({tag, "_ds2"},     dataSource2, e.ds2);
        chk({tag, "_imm"},     immValue,    e.imm);
        chk({tag, "_pc"},      pcOut,       e.pc);
        chk({tag, "_rd"},      rdAddr,      e.rd);
        chk({tag, "_illegal"}, illegal,     e.ill);
    endtask

    // Expected bundle for an instruction, with operands read from the model registers.
    function automatic bundle_t model_bundle(input logic [31:0] inst, input logic [31:0] pc);
        bundle_t b;
        int      simm;
        b.op  = inst[6:0];
        b.f3  = inst[14:12];
        b.f7  = inst[31:25];
        b.pc  = pc;
        b.ds1 = 0;
        b.ds2 = 0;
        b.imm = 0;
        b.rd  = 0;
        b.ill = 1'b1;
        simm = int'(inst[31:20]);
        if (simm >= 2048) simm = simm - 4096;
        if (b.op == 7'h13) begin
            b.ill = 1'b0;
            b.rd  = inst[11:7];
            b.ds1 = mregs[inst[19:15]];
            b.imm = 32'(simm);
        end else if (b.op == 7'h33) begin
            b.ill = 1'b0;
            b.rd  = inst[11:7];
            b.ds1 = mregs[inst[19:15]];
            b.ds2 = mregs[inst[24:20]];
        end
        return b;
    endfunction

    function automatic vec_t mkvec(input string name, input logic [31:0] inst,
                                   input logic [31:0] pc, input logic [6:0] op,
                                   input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [31:0] ds1, input logic [31:0] ds2,
                                   input logic [31:0] imm, input logic [4:0] rd,
                                   input logic ill);
        vec_t v;
        v.name    = name;
        v.inst    = inst;
        v.pc      = pc;
        v.exp.op  = op;
        v.exp.f3  = f3;
        v.exp.f7  = f7;
        v.exp.ds1 = ds1;
        v.exp.ds2 = ds2;
        v.exp.imm = imm;
        v.exp.pc  = pc;
        v.exp.rd  = rd;
        v.exp.ill = ill;
        return v;
    endfunction

    task automatic check_model();
        logic exp_rdy;
        exp_rdy = (!m_valid || outReady) && !flush;
        chk("instReady", instReady, exp_rdy);
        chk("outValid", outValid, m_valid);
        if (m_valid) chk_bundle("model", model_bundle(m_inst, m_pc));
    endtask

    task automatic update_model();
        if (instValid && (!m_valid || outReady) && !flush) begin
            m_valid = 1'b1;
            m_inst  = instIn;
            m_pc    = instPc;
        end else if (flush || (m_valid && outReady)) begin
            m_valid = 1'b0;
        end
        if (wbEn && (wbAddr != 0)) mregs[wbAddr] = wbData;
    endtask

    // One clock: drive, check at the falling edge, advance model at the rising edge.
    task automatic step(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic we,
                        input logic [4:0] wa, input logic [31:0] wd);
        instValid = iv;
        instIn    = inst;
        instPc    = pc;
        outReady  = ordy;
        flush     = fl;
        wbEn      = we;
        wbAddr    = wa;
        wbData    = wd;
        @(negedge clk);
        check_model();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic do_reset();
        bundle_t z;
        z = '{7'h0, 3'h0, 7'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'h0, 1'b0};
        rst_n = 1'b0;
        #1;
        chk("rst_outValid", outValid, 1'b0);
        chk_bundle("rst", z);
        m_valid = 1'b0;
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mregs[i] = '0;
        #1;
        do_reset();

        // Preload x1=0xF0, x3=0x10; the x0 write must be dropped.
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h0000_00F0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0010);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0000_DEAD);

        vecs.push_back(mkvec("ori",   32'h00F0E113, 32'h1000, 7'h13, 3'd6, 7'h00,
                             32'hF0, 32'h0, 32'h0000_000F, 5'd2, 1'b0));
        vecs.push_back(mkvec("addim1", 32'hFFF08213, 32'h1004, 7'h13, 3'd0, 7'h7F,
                             32'hF0, 32'h0, 32'hFFFF_FFFF, 5'd4, 1'b0));
        vecs.push_back(mkvec("add",   32'h00308333, 32'h1008, 7'h33, 3'd0, 7'h00,
                             32'hF0, 32'h10, 32'h0, 5'd6, 1'b0));
        vecs.push_back(mkvec("sub",   32'h401183B3, 32'h100C, 7'h33, 3'd0, 7'h20,
                             32'h10, 32'hF0, 32'h0, 5'd7, 1'b0));
        vecs.push_back(mkvec("lw",    32'h0000A083, 32'h1010, 7'h03, 3'd2, 7'h00,
                             32'h0, 32'h0, 32'h0, 5'd0, 1'b1));
        vecs.push_back(mkvec("addix0", 32'h7FF00413, 32'h1014, 7'h13, 3'd0, 7'h3F,
                             32'h0, 32'h0, 32'h0000_07FF, 5'd8, 1'b0));
        vecs.push_back(mkvec("xorx0", 32'h003044B3, 32'h1018, 7'h33, 3'd4, 7'h00,
                             32'h0, 32'h10, 32'h0, 5'd9, 1'b0));
        vecs.push_back(mkvec("andi",  32'h8000F513, 32'h101C, 7'h13, 3'd7, 7'h40,
                             32'hF0, 32'h0, 32'hFFFF_F800, 5'd10, 1'b0));
        vecs.push_back(mkvec("jal",   32'h0040006F, 32'h1020, 7'h6F, 3'd0, 7'h00,
                             32'h0, 32'h0, 32'h0, 5'd0, 1'b1));

        foreach (vecs[i]) begin
            step(1'b1, vecs[i].inst, vecs[i].pc, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
            chk({vecs[i].name, "_valid"}, outValid, 1'b1);
            chk_bundle(vecs[i].name, vecs[i].exp);
        end

        // Stall: ADDI x2,x1,5 held for three cycles while ADD x6,x1,x3 waits.
        step(1'b1, 32'h00508113, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h00308333, 32'h104, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
            chk("stall_ready", instReady, 1'b0);
            chk("stall_pc", pcOut, 32'h100);
            chk("stall_imm", immValue, 32'h5);
        end
        step(1'b1, 32'h00308333, 32'h104, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("release_pc", pcOut, 32'h104);
        chk("release_ds2", dataSource2, 32'h10);

        // Write-through on accept, then operand refresh while held.
        step(1'b1, 32'h00328593, 32'h200, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0000_1234);
        chk("wt_ds1", dataSource1, 32'h1234);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_5678);
        chk("refresh_ds1", dataSource1, 32'h5678);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_AAAA);
        chk("itype_ds2", dataSource2, 32'h0);
        step(1'b1, 32'h00308333, 32'h204, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_BEEF);
        chk("rtype_ds2", dataSource2, 32'hBEEF);

        // Flush with a held bundle and an incoming instruction.
        step(1'b1, 32'h00508113, 32'h300, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
        chk("flush_ready", instReady, 1'b0);
        chk("flush_valid", outValid, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("flush_dropped", outValid, 1'b0);

        // Illegal load, stall, then reset in the middle of the stall.
        step(1'b1, 32'h0000A083, 32'h400, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("ld_valid", outValid, 1'b1);
        chk("ld_illegal", illegal, 1'b1);
        chk("ld_imm", immValue, 32'h0);
        step(1'b1, 32'h00508113, 32'h404, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        do_reset();
        step(1'b1, 32'h00508113, 32'h500, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
        chk("postrst_valid", outValid, 1'b1);
        chk("postrst_x1", dataSource1, 32'h0);
        chk("postrst_imm", immValue, 32'h5);

        for (int n = 0; n < 600; n++) begin
            logic [31:0] ri;
            int          sel;
            ri  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 4) ri[6:0] = 7'h13;
            else if (sel < 8) ri[6:0] = 7'h33;
            ri[19:15] = 5'($urandom_range(0, 7));
            ri[24:20] = 5'($urandom_range(0, 7));
            step($urandom_range(0, 9) < 7, ri, $urandom, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 7)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
